// File: rtl/axis_tap_capture_if.sv
//------------------------------------------------------------------------------
// Module : axis_tap_capture_if
// Brief  : Monitored AXI-Stream link signals (valid/ready/data) seen by the tap.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axis_tap_capture_if #(
  parameter int TDATA_WIDTH = 64
);
  logic                   tready;
  logic                   tvalid;
  logic [TDATA_WIDTH-1:0] tdata;

  // master drives the whole link (source plus sink ready); slave only observes it
  modport master (output tvalid, output tdata, output tready);
  modport slave  (input  tvalid, input  tdata, input  tready);
endinterface

`default_nettype wire

// File: rtl/axis_tap_capture.sv
//------------------------------------------------------------------------------
// Module : axis_tap_capture
// Brief  : Passive AXI-Stream tap with a live field snoop, decimated burst
//          capture buffer and saturating beat/stall counters.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_tap_capture #(
  parameter int TDATA_WIDTH = 64,
  parameter int FIELD_LSB   = 32,
  parameter int FIELD_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  wire logic                   s00_axis_aclk,
  input  wire logic                   s00_axis_aresetn,
  axis_tap_capture_if.slave           tap,
  input  wire logic                   arm,
  input  wire logic                   abort,
  input  wire logic [DECIM_WIDTH-1:0] decim,
  input  wire logic                   clear,
  input  wire logic                   rd_en,
  output logic [FIELD_WIDTH-1:0]      snooped_tdata,
  output logic                        snooped_valid,
  output logic [FIELD_WIDTH-1:0]      rd_data,
  output logic                        rd_valid,
  output logic [1:0]                  state,
  output logic [31:0]                 beat_count,
  output logic [31:0]                 stall_count
);

  localparam int             c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_arm_acc;
  logic                    w_cap_hs;
  logic                    w_wr_en;
  logic                    w_rd_acc;

  logic [TDATA_WIDTH-1:0]  w_tdata;
  logic [FIELD_WIDTH-1:0]  w_field;
  logic                    w_hs;
  logic                    w_stall;
  logic                    w_unused_tdata;

  logic [FIELD_WIDTH-1:0]  r_snoop;
  logic                    r_snoop_vld;
  logic [31:0]             r_beat;
  logic [31:0]             r_stall;
  logic [DECIM_WIDTH-1:0]  r_decim;
  logic [DECIM_WIDTH-1:0]  r_dcnt;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [FIELD_WIDTH-1:0]  r_rd_data;
  logic                    r_rd_valid;
  logic [FIELD_WIDTH-1:0]  r_mem [DEPTH];

  assign w_tdata        = tap.tdata;
  assign w_field        = w_tdata[FIELD_LSB +: FIELD_WIDTH];
  assign w_hs           = tap.tvalid & tap.tready;
  assign w_stall        = tap.tvalid & ~tap.tready;
  assign w_unused_tdata = &{1'b0, w_tdata};

  // Live snoop path and diagnostics counters run regardless of FSM state
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_snoop     <= '0;
      r_snoop_vld <= 1'b0;
      r_beat      <= '0;
      r_stall     <= '0;
    end else begin
      r_snoop_vld <= w_hs;
      if (w_hs) r_snoop <= w_field;
      if (clear) begin
        r_beat  <= '0;
        r_stall <= '0;
      end else begin
        if (w_hs && (r_beat != '1))     r_beat  <= r_beat + 32'd1;
        if (w_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) r_state <= ST_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_acc   = 1'b0;
    w_cap_hs    = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_acc    = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (arm) begin
            w_arm_acc   = 1'b1;
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          w_cap_hs = w_hs;
          w_wr_en  = w_hs && (r_dcnt == '0);
          if (w_wr_en && (r_wr_ptr == c_LAST)) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          w_rd_acc = rd_en;
          if (rd_en && (r_rd_ptr == c_LAST)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_decim    <= '0;
      r_dcnt     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_arm_acc) begin
        r_decim  <= decim;
        r_dcnt   <= '0;
        r_wr_ptr <= '0;
      end else if (w_cap_hs) begin
        // dcnt == 0 marks a kept sample; otherwise count down the skipped beats
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_dcnt   <= r_decim;
          if (r_wr_ptr == c_LAST) r_rd_ptr <= '0;
        end else begin
          r_dcnt <= r_dcnt - 1'b1;
        end
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_field;
  end

  assign snooped_tdata = r_snoop;
  assign snooped_valid = r_snoop_vld;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign state         = r_state;
  assign beat_count    = r_beat;
  assign stall_count   = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_axis_tap_capture.sv
//------------------------------------------------------------------------------
// Module : tb_axis_tap_capture
// Brief  : Self-checking bench for axis_tap_capture against a queue-based model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_tap_capture;

  localparam int TDW   = 64;
  localparam int FLSB  = 32;
  localparam int FW    = 32;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam longint unsigned c_SAT = 64'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_tap_capture_if #(.TDATA_WIDTH(TDW)) tap_if ();

  logic          arm   = 1'b0;
  logic          abort = 1'b0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] decim = '0;
  logic [FW-1:0] snooped_tdata;
  logic          snooped_valid;
  logic [FW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;

  axis_tap_capture #(
    .TDATA_WIDTH(TDW), .FIELD_LSB(FLSB), .FIELD_WIDTH(FW),
    .DEPTH(DEPTH), .DECIM_WIDTH(DW)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .tap             (tap_if),
    .arm             (arm),
    .abort           (abort),
    .decim           (decim),
    .clear           (clear),
    .rd_en           (rd_en),
    .snooped_tdata   (snooped_tdata),
    .snooped_valid   (snooped_valid),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .state           (state),
    .beat_count      (beat_count),
    .stall_count     (stall_count)
  );

  // Reference model: capture is "keep every (decim+1)-th handshake since arm"
  logic [FW-1:0]   m_snoop, m_rd_data;
  bit              m_sv, m_rdv;
  longint unsigned m_beat, m_stall;
  int              m_state, m_decim, m_idx;
  logic [FW-1:0]   m_cap[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_snoop = '0; m_rd_data = '0; m_sv = 0; m_rdv = 0;
    m_beat = 0; m_stall = 0; m_state = 0; m_decim = 0; m_idx = 0;
    m_cap.delete();
  endtask

  task automatic model_update();
    logic [TDW-1:0] d;
    logic [FW-1:0]  f;
    bit             hs, st;
    d  = tap_if.tdata;
    f  = d[FLSB +: FW];
    hs = tap_if.tvalid & tap_if.tready;
    st = tap_if.tvalid & ~tap_if.tready;
    m_sv = hs;
    if (hs) m_snoop = f;
    if (clear) begin
      m_beat = 0; m_stall = 0;
    end else begin
      if (hs && m_beat < c_SAT) m_beat++;
      if (st && m_stall < c_SAT) m_stall++;
    end
    m_rdv = 0;
    if (abort) begin
      m_state = 0;
      m_cap.delete();
    end else if (m_state == 0) begin
      if (arm) begin
        m_decim = int'(decim); m_idx = 0; m_cap.delete(); m_state = 1;
      end
    end else if (m_state == 1) begin
      if (hs) begin
        if (m_idx % (m_decim + 1) == 0) m_cap.push_back(f);
        m_idx++;
        if (m_cap.size() == DEPTH) m_state = 2;
      end
    end else begin
      if (rd_en) begin
        m_rd_data = m_cap.pop_front();
        m_rdv     = 1;
        if (m_cap.size() == 0) m_state = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("state",         64'(state),         64'(m_state));
    chk("snooped_valid", 64'(snooped_valid), 64'(m_sv));
    chk("snooped_tdata", 64'(snooped_tdata), 64'(m_snoop));
    chk("rd_valid",      64'(rd_valid),      64'(m_rdv));
    chk("rd_data",       64'(rd_data),       64'(m_rd_data));
    chk("beat_count",    64'(beat_count),    m_beat);
    chk("stall_count",   64'(stall_count),   m_stall);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic drv(input bit tv, input bit tr, input logic [FW-1:0] f);
    logic [TDW-1:0] d;
    d = {$urandom, $urandom};
    d[FLSB +: FW] = f;
    tap_if.tvalid = tv;
    tap_if.tready = tr;
    tap_if.tdata  = d;
  endtask

  // Called just after a posedge; asserts reset asynchronously mid-cycle
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic arm_capture(input logic [DW-1:0] dcm);
    decim = dcm; arm = 1'b1; drv(0, 0, '0);
    step();
    arm = 1'b0;
  endtask

  initial begin
    int pulses;
    drv(0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Live path only
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, FW'(32'h11 + i));
      step();
      if (snooped_valid) pulses++;
    end
    drv(0, 0, '0);
    step();
    chk("t1_pulses", 64'(pulses), 64'd5);
    chk("t1_snoop",  64'(snooped_tdata), 64'h15);
    chk("t1_beats",  64'(beat_count), 64'd5);
    chk("t1_state",  64'(state), 64'd0);

    // Full-rate capture and back-to-back readout
    arm_capture(8'd0);
    for (int i = 0; i < DEPTH; i++) begin drv(1, 1, FW'(i)); step(); end
    chk("t2_done", 64'(state), 64'd2);
    drv(0, 0, '0); rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t2_rd", 64'(rd_data), 64'(i));
      chk("t2_rdv", 64'(rd_valid), 64'd1);
    end
    rd_en = 1'b0;
    step();
    chk("t2_idle", 64'(state), 64'd0);

    // Decimated capture, decim changed mid-capture
    arm_capture(8'd2);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (i == 20) decim = 8'd7;
      drv(1, 1, FW'(i)); step();
    end
    chk("t3_done", 64'(state), 64'd2);
    drv(0, 0, '0); rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t3_rd", 64'(rd_data), 64'(3 * i));
    end
    rd_en = 1'b0;
    step();

    // Stall counting and clear-wins
    clear = 1'b1; drv(0, 0, '0); step(); clear = 1'b0;
    for (int i = 0; i < 7; i++) begin drv(1, 0, FW'($urandom)); step(); end
    chk("t4_stall", 64'(stall_count), 64'd7);
    drv(1, 1, 32'hABCD); clear = 1'b1; step(); clear = 1'b0;
    chk("t4_beat_clr",  64'(beat_count), 64'd0);
    chk("t4_stall_clr", 64'(stall_count), 64'd0);

    // Abort coincident with a handshake, then restart
    arm_capture(8'd0);
    for (int i = 0; i < 5; i++) begin drv(1, 1, FW'(200 + i)); step(); end
    drv(1, 1, FW'(999)); abort = 1'b1; step(); abort = 1'b0;
    chk("t5_idle", 64'(state), 64'd0);
    drv(0, 0, '0); rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t5_rd_ignored", 64'(rd_valid), 64'd0);
    arm_capture(8'd0);
    for (int i = 0; i < DEPTH; i++) begin drv(1, 1, FW'(300 + i)); step(); end
    drv(0, 0, '0); rd_en = 1'b1; step();
    chk("t5_first", 64'(rd_data), 64'd300);
    for (int i = 1; i < DEPTH; i++) step();
    rd_en = 1'b0;
    step();

    // Reset in DONE after three reads
    arm_capture(8'd1);
    for (int i = 0; i < 2 * DEPTH; i++) begin drv(1, 1, FW'($urandom)); step(); end
    drv(0, 0, '0); rd_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd_en = 1'b0;
    async_reset();
    chk("t6_rdv",   64'(rd_valid), 64'd0);
    chk("t6_state", 64'(state), 64'd0);
    chk("t6_beats", 64'(beat_count), 64'd0);
    step();
    chk("t6_rdv_after", 64'(rd_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom % 4) != 0, ($urandom % 3) != 0, FW'($urandom));
      arm   = ($urandom % 20) == 0;
      decim = DW'($urandom % 4);
      rd_en = $urandom % 2;
      abort = ($urandom % 150) == 0;
      clear = ($urandom % 200) == 0;
      step();
      if (($urandom % 700) == 0) begin
        arm = 0; abort = 0; clear = 0; rd_en = 0; drv(0, 0, '0);
        async_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_tap_capture.md
# axis_tap_capture

Passive, parametrised AXI-Stream tap that sits beside a stream link, such as the CORDIC output into the downstream consumer, without ever driving `tready` or applying backpressure. It extracts a configurable bit field from every completed handshake and keeps the latest value live. On command it captures a decimated burst of `DEPTH` fields into an internal buffer for later readout. It also maintains saturating beat and stall counters for link diagnostics.

## Interface
Parameters:
- `TDATA_WIDTH`, 64, width of the monitored `tdata` bus
- `FIELD_LSB`, 32, lowest bit of the extracted field within `tdata`
- `FIELD_WIDTH`, 32, width of the extracted field; `FIELD_LSB + FIELD_WIDTH <= TDATA_WIDTH`
- `DEPTH`, 16, capture buffer depth in samples; power of two, at least 2
- `DECIM_WIDTH`, 8, width of the decimation control

Ports:
- `s00_axis_aclk`, in, 1, single clock for all logic
- `s00_axis_aresetn`, in, 1, asynchronous active-low reset
- `tap_tready`, in, 1, monitored sink ready (observe only)
- `tap_tvalid`, in, 1, monitored source valid (observe only)
- `tap_tdata`, in, `TDATA_WIDTH`, monitored data
- `arm`, in, 1, single-cycle pulse that starts a capture; honoured only in IDLE
- `abort`, in, 1, returns the block to IDLE from any state
- `decim`, in, `DECIM_WIDTH`, stores 1 of every `decim+1` handshakes; latched when `arm` is accepted
- `clear`, in, 1, zeroes `beat_count` and `stall_count`
- `rd_en`, in, 1, pops one buffered sample; honoured only in DONE
- `snooped_tdata`, out, `FIELD_WIDTH`, field of the most recent handshake
- `snooped_valid`, out, 1, one-cycle pulse marking a `snooped_tdata` update
- `rd_data`, out, `FIELD_WIDTH`, buffered sample readout
- `rd_valid`, out, 1, `rd_data` is valid this cycle
- `state`, out, 2, encoding 0 = IDLE, 1 = CAPTURE, 2 = DONE
- `beat_count`, out, 32, saturating count of handshakes
- `stall_count`, out, 32, saturating count of cycles with `tvalid & !tready`

## Operation
- Handshake definition: `hs = tap_tvalid & tap_tready`.
- Field extraction: `field = tap_tdata[FIELD_LSB +: FIELD_WIDTH]`.
- Live path: on every `hs`, load `snooped_tdata <= field` and pulse `snooped_valid` high for exactly one cycle. With no `hs`, `snooped_tdata` holds its value.
- Beat counter: `beat_count` increments on each `hs` and saturates at 2^32-1.
- Stall counter: `stall_count` increments on each cycle with `tvalid & !tready` and saturates at 2^32-1.
- `clear` zeroes both counters. If an event coincides with `clear`, `clear` wins and the counter ends at 0.
- FSM, IDLE:
  - `arm` latches `decim`, sets `wr_ptr = 0` and `dcnt = 0`, then moves to CAPTURE.
  - `rd_en` is ignored.
- FSM, CAPTURE:
  - On each `hs` with `dcnt == 0`: write `buf[wr_ptr] <= field`, increment `wr_ptr`, reload `dcnt = decim_latched`.
  - On each `hs` with `dcnt != 0`: decrement `dcnt` only.
  - The write that fills entry `DEPTH-1` moves the FSM to DONE and sets `rd_ptr = 0`.
  - `arm` and `rd_en` are ignored.
- FSM, DONE:
  - `rd_en` loads `rd_data <= buf[rd_ptr]`, asserts `rd_valid` next cycle, and increments `rd_ptr`.
  - The read of entry `DEPTH-1` moves the FSM to IDLE.
  - `arm` is ignored.
  - Handshakes update the live path and counters only; the buffer is frozen.
- `abort` forces IDLE from any state and takes priority over `arm`, `hs` writes and `rd_en` in the same cycle. Buffer contents are left undefined-but-unused.
- The live path and counters run in every state and are unaffected by `abort`.

## Timing
- Reset, asynchronous: all outputs are 0, `state` is IDLE, and all pointers and `dcnt` are 0. Buffer contents need no reset.
- `snooped_tdata` and `snooped_valid` appear one cycle after the `hs` edge (registered).
- A handshake in the same cycle as the accepted `arm` is not captured; the first capture candidate is the first `hs` after the `arm` edge.
- `state` reads DONE in the cycle after the edge where the last write occurs.
- Read latency is 1 cycle: `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1. Back-to-back `rd_en` sustains one sample per cycle.
- `rd_valid` is low whenever no accepted `rd_en` occurred in the prior cycle.
- Asserting reset mid-capture or mid-readout returns the block immediately to IDLE with all outputs at 0.

## Test plan
- Reset, then 5 handshakes with field values 0x11..0x15 and no `arm`: `snooped_tdata` = 0x15, 5 `snooped_valid` pulses, `beat_count` = 5, `state` = IDLE.
- `decim` = 0, `arm`, then 16 consecutive handshakes with field values 0..15: `state` = DONE after the 16th; 16 back-to-back `rd_en` return 0..15 with `rd_valid` high for 16 cycles; `state` = IDLE afterwards.
- `decim` = 2, `arm`, then 48 handshakes with field value = index: buffer holds 0,3,6,…,45; `decim` changed mid-capture has no effect.
- Hold `tvalid = 1`, `tready = 0` for 7 cycles, then pulse `clear` in the same cycle as a handshake: `stall_count` = 7 before `clear`, and both counters read 0 after.
- `arm`, 5 captured samples, `abort` coincident with a handshake: `state` = IDLE next cycle, no write occurs, `rd_en` is ignored, and a new `arm` restarts at `wr_ptr` = 0.
- Assert reset in DONE after 3 reads: all outputs are 0 and `state` = IDLE, with no glitch on `rd_valid`.
